// File: rtl/wb_write_arbiter.sv
// Merges the two MEM/WB writeback streams onto one register-file write port.
// An ordered pending queue absorbs the second write and a look-ahead stall prevents overflow.
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              wb1_flag_we,
  input  logic [3:0]        wb1_flags,
  input  logic              wb2_valid,
  input  logic [ADDR_W-1:0] wb2_rd,
  input  logic [DATA_W-1:0] wb2_data,
  input  logic              wb2_flag_we,
  input  logic [3:0]        wb2_flags,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_we,
  output logic [3:0]        flag_val,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int SEQ_N = DEPTH + 1;
  localparam int CNT_W = $clog2(SEQ_N + 1);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  seqLen;
  logic [CNT_W-1:0]  countNext;
  logic [ADDR_W-1:0] qAddr   [DEPTH];
  logic [DATA_W-1:0] qData   [DEPTH];
  logic [ADDR_W-1:0] seqAddr [SEQ_N];
  logic [DATA_W-1:0] seqData [SEQ_N];
  logic              accept;
  logic              e1;
  logic              e2;
  logic              nonEmpty;

  // Stalling at DEPTH-1 occupants always leaves room for a full pair.
  assign stall     = count > CNT_W'(DEPTH - 2);
  assign accept    = !stall;
  assign e1        = wb1_valid & accept & ~(wb2_valid & (wb1_rd == wb2_rd));
  assign e2        = wb2_valid & accept;
  assign seqLen    = count + CNT_W'(e1) + CNT_W'(e2);
  assign nonEmpty  = seqLen != '0;
  assign countNext = seqLen - CNT_W'(nonEmpty);

  // Stage p0: logical sequence = queued entries, then e1, then e2
  always_comb begin
    for (int i = 0; i < SEQ_N; i++) begin
      seqAddr[i] = '0;
      seqData[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        seqAddr[i] = qAddr[i];
        seqData[i] = qData[i];
      end
    end
    for (int i = 0; i < SEQ_N; i++) begin
      if (e1 && (CNT_W'(i) == count)) begin
        seqAddr[i] = wb1_rd;
        seqData[i] = wb1_data;
      end
      if (e2 && (CNT_W'(i) == count + CNT_W'(e1))) begin
        seqAddr[i] = wb2_rd;
        seqData[i] = wb2_data;
      end
    end
  end

  // Stage p1: head retires, remainder shifts down; slots beyond count are don't-care
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      qAddr[i] <= seqAddr[i+1];
      qData[i] <= seqData[i+1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      flag_we  <= 1'b0;
      flag_val <= '0;
    end else begin
      count <= countNext;
      rf_we <= nonEmpty;
      if (nonEmpty) begin
        rf_addr  <= seqAddr[0];
        rf_wdata <= seqData[0];
      end
      if (accept && wb2_flag_we) begin
        flag_we  <= 1'b1;
        flag_val <= wb2_flags;
      end else if (accept && wb1_flag_we) begin
        flag_we  <= 1'b1;
        flag_val <= wb1_flags;
      end else begin
        flag_we  <= 1'b0;
      end
    end
  end

  // Ascending scan lets the youngest matching entry win.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (qAddr[i] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = qData[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wb1_valid = 1'b0, wb2_valid = 1'b0;
  logic [ADDR_W-1:0] wb1_rd = '0, wb2_rd = '0, fwd_addr = '0;
  logic [DATA_W-1:0] wb1_data = '0, wb2_data = '0;
  logic              wb1_flag_we = 1'b0, wb2_flag_we = 1'b0;
  logic [3:0]        wb1_flags = '0, wb2_flags = '0;
  logic              stall, rf_we, flag_we, fwd_hit;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata, fwd_data;
  logic [3:0]        flag_val;

  wb_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .wb1_flag_we(wb1_flag_we), .wb1_flags(wb1_flags),
    .wb2_valid(wb2_valid), .wb2_rd(wb2_rd), .wb2_data(wb2_data),
    .wb2_flag_we(wb2_flag_we), .wb2_flags(wb2_flags),
    .stall(stall), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .flag_we(flag_we), .flag_val(flag_val),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrEntry_t;

  wrEntry_t          mq[$];
  logic              expRfWe = 1'b0;
  logic [ADDR_W-1:0] expRfAddr = '0;
  logic [DATA_W-1:0] expRfData = '0;
  logic              expFlagWe = 1'b0;
  logic [3:0]        expFlagVal = '0;
  int                nChecks = 0;
  int                nFails = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkVal({tag, ".rf_we"}, 64'(rf_we), 64'(expRfWe));
    checkVal({tag, ".rf_addr"}, 64'(rf_addr), 64'(expRfAddr));
    checkVal({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(expRfData));
    checkVal({tag, ".flag_we"}, 64'(flag_we), 64'(expFlagWe));
    checkVal({tag, ".flag_val"}, 64'(flag_val), 64'(expFlagVal));
  endtask

  task automatic modelReset();
    mq.delete();
    expRfWe = 1'b0; expRfAddr = '0; expRfData = '0;
    expFlagWe = 1'b0; expFlagVal = '0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic runCycle(
    input logic v1, input logic [ADDR_W-1:0] rd1, input logic [DATA_W-1:0] d1,
    input logic f1we, input logic [3:0] f1,
    input logic v2, input logic [ADDR_W-1:0] rd2, input logic [DATA_W-1:0] d2,
    input logic f2we, input logic [3:0] f2,
    input logic [ADDR_W-1:0] fa, input string tag);
    logic              acc, hitExp;
    logic [DATA_W-1:0] fwdExp;
    wrEntry_t          e;
    wb1_valid = v1; wb1_rd = rd1; wb1_data = d1; wb1_flag_we = f1we; wb1_flags = f1;
    wb2_valid = v2; wb2_rd = rd2; wb2_data = d2; wb2_flag_we = f2we; wb2_flags = f2;
    fwd_addr = fa;
    #1;
    acc = !(mq.size() > DEPTH - 2);
    checkVal({tag, ".stall"}, 64'(stall), 64'(!acc));
    hitExp = 1'b0;
    fwdExp = '0;
    foreach (mq[i]) if (mq[i].addr == fa) begin hitExp = 1'b1; fwdExp = mq[i].data; end
    checkVal({tag, ".fwd_hit"}, 64'(fwd_hit), 64'(hitExp));
    checkVal({tag, ".fwd_data"}, 64'(fwd_data), 64'(fwdExp));
    if (acc && v1 && !(v2 && rd1 == rd2)) begin e.addr = rd1; e.data = d1; mq.push_back(e); end
    if (acc && v2) begin e.addr = rd2; e.data = d2; mq.push_back(e); end
    if (mq.size() > 0) begin
      e = mq.pop_front();
      expRfWe = 1'b1; expRfAddr = e.addr; expRfData = e.data;
    end else begin
      expRfWe = 1'b0;
    end
    if (acc && f2we) begin expFlagWe = 1'b1; expFlagVal = f2; end
    else if (acc && f1we) begin expFlagWe = 1'b1; expFlagVal = f1; end
    else expFlagWe = 1'b0;
    @(negedge clk);
    checkRegs(tag);
  endtask

  task automatic idle(input logic [ADDR_W-1:0] fa, input string tag);
    runCycle(0, '0, '0, 0, '0, 0, '0, '0, 0, '0, fa, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", nChecks);
    $fatal(1);
  end

  initial begin
    int k, iter;
    logic willAcc;
    modelReset();
    @(negedge clk);
    checkRegs("rst");
    checkVal("rst.stall", 64'(stall), 64'(0));
    reset = 1'b1;

    // single write into empty queue
    runCycle(1, 3'd3, 32'hDEADBEEF, 0, '0, 0, '0, '0, 0, '0, '0, "t2");
    checkVal("t2.addr", 64'(rf_addr), 64'd3);
    checkVal("t2.data", 64'(rf_wdata), 64'hDEADBEEF);
    idle('0, "t2b");
    checkVal("t2b.we", 64'(rf_we), 64'd0);

    // pair: second write waits one cycle and is forwardable meanwhile
    runCycle(1, 3'd1, 32'h11, 0, '0, 1, 3'd2, 32'h22, 0, '0, 3'd2, "t3");
    checkVal("t3.addr", 64'(rf_addr), 64'd1);
    checkVal("t3.fwdhit", 64'(fwd_hit), 64'd1);
    checkVal("t3.fwddata", 64'(fwd_data), 64'h22);
    idle(3'd2, "t3b");
    checkVal("t3b.addr", 64'(rf_addr), 64'd2);
    checkVal("t3b.data", 64'(rf_wdata), 64'h22);

    // WAW: younger wins, single write
    runCycle(1, 3'd5, 32'hA, 0, '0, 1, 3'd5, 32'hB, 0, '0, 3'd5, "t4");
    checkVal("t4.data", 64'(rf_wdata), 64'hB);
    checkVal("t4.stall", 64'(stall), 64'd0);
    idle(3'd5, "t4b");
    checkVal("t4b.we", 64'(rf_we), 64'd0);

    // back-to-back pairs until stall; upstream re-presents a stalled pair
    k = 0;
    iter = 0;
    while (k < 4 && iter < 20) begin
      willAcc = !(mq.size() > DEPTH - 2);
      runCycle(1, ADDR_W'(k), 32'h100 + 32'(2*k), 0, '0,
               1, ADDR_W'(k + 4), 32'h101 + 32'(2*k), 0, '0, ADDR_W'(k + 4), "t5");
      if (willAcc) k++;
      if (k == 3 && iter == 2) checkVal("t5.stall3", 64'(stall), 64'd1);
      iter++;
    end
    checkVal("t5.done", 64'(k), 64'd4);

    // asynchronous reset with a full queue and an active write
    checkVal("t1.pre_we", 64'(rf_we), 64'd1);
    reset = 1'b0;
    #1;
    modelReset();
    checkRegs("t1");
    checkVal("t1.stall", 64'(stall), 64'd0);
    checkVal("t1.fwd", 64'(fwd_hit), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    idle('0, "t1b");
    checkVal("t1b.we", 64'(rf_we), 64'd0);

    // flag merge, then suppressed under stall
    runCycle(0, '0, '0, 1, 4'h8, 0, '0, '0, 1, 4'h4, '0, "t6");
    checkVal("t6.we", 64'(flag_we), 64'd1);
    checkVal("t6.val", 64'(flag_val), 64'h4);
    for (int i = 0; i < 3; i++)
      runCycle(1, ADDR_W'(i), 32'(i), 0, '0, 1, ADDR_W'(i + 4), 32'(i + 9), 0, '0, '0, "t6f");
    checkVal("t6.stallpre", 64'(stall), 64'd1);
    runCycle(0, '0, '0, 1, 4'h8, 0, '0, '0, 1, 4'h4, '0, "t6s");
    checkVal("t6s.we", 64'(flag_we), 64'd0);
    for (int i = 0; i < 4; i++) idle('0, "t6d");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      runCycle($urandom_range(3) != 0, ADDR_W'($urandom), $urandom, 1'($urandom), 4'($urandom),
               $urandom_range(3) != 0, ADDR_W'($urandom), $urandom, 1'($urandom), 4'($urandom),
               ADDR_W'($urandom), "rnd");
    end
    for (int i = 0; i < 5; i++) idle(ADDR_W'(i), "drain");
    checkVal("drain.we", 64'(rf_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
